// File: rtl/ft_tx_engine.sv
// ----------------------------------------------------------------------------
// ft_tx_engine
//   Transmit engine for an FT245-style parallel FIFO interface. Bytes offered
//   by the upstream stage are buffered and then written to the chip one at a
//   time. Each write is a fixed sequence: SETUP, STROBE, HOLD, RECOVER.
//
// Build option
//   FT_TX_FIFO_EN : defined   -> FIFO_DEPTH-entry circular buffer
//                   undefined -> single-byte holding register (level 0/1)
//
// Parameters
//   FIFO_DEPTH    : buffer entries, power of two, 2..64
//   STROBE_CYCLES : wr pulse width in clk cycles, 1..15
//   RECOVER_MAX   : upper bound on cycles spent waiting for txe high
//
// Ports
//   clk       : clock, rising edge only
//   reset_in  : synchronous reset, active-low
//   in_data   : upstream byte
//   in_valid  : upstream byte valid
//   in_ready  : engine can accept a byte this cycle
//   txe       : chip transmit-space flag, active-low
//   wr        : chip write strobe, active-high (chip latches on falling edge)
//   data_out  : chip data bus
//   data_oe   : data bus output enable
//   level     : number of buffered bytes
// ----------------------------------------------------------------------------
module ft_tx_engine #(
    parameter int FIFO_DEPTH    = 8,
    parameter int STROBE_CYCLES = 2,
    parameter int RECOVER_MAX   = 4
) (
    input  logic       clk,
    input  logic       reset_in,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       txe,
    output logic       wr,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [6:0] level
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

`ifdef FT_TX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    // Holding register only; FIFO_DEPTH does not size anything in this build.
    localparam int CAP = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_data_out;
    logic [6:0] r_level;
    logic [7:0] w_head;
    logic       w_push;
    logic       w_pop;

    // Readiness depends only on registered level and reset, never on in_valid,
    // so a pop in HOLD cannot open a slot for a push in the same cycle.
    assign in_ready = reset_in && (r_level < 7'(CAP));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_HOLD);

    // ------------------------------------------------------------------
    // Byte storage
    // ------------------------------------------------------------------
`ifdef FT_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    assign w_head = r_mem[r_rptr];
`else
    logic [7:0] r_hold;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_hold <= in_data;
        end
    end

    assign w_head = r_hold;
`endif

    // ------------------------------------------------------------------
    // Fill level
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 7'd1;
                2'b01:   r_level <= r_level - 7'd1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign level = r_level;

    // ------------------------------------------------------------------
    // Write state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((r_level != 7'd0) && !txe) begin
                        // Head byte is captured once and held until the pop.
                        r_data_out <= w_head;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_cnt == 8'(STROBE_CYCLES - 1)) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    r_cnt   <= '0;
                    r_state <= S_RECOVER;
                end
                S_RECOVER: begin
                    if (txe || (r_cnt == 8'(RECOVER_MAX - 1))) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr       = (r_state == S_STROBE);
    assign data_oe  = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
    assign data_out = r_data_out;

endmodule

// File: tb/tb_ft_tx_engine.sv
// ----------------------------------------------------------------------------
// tb_ft_tx_engine
//   Self-checking bench for ft_tx_engine. A queue of accepted bytes is the
//   reference: every wr pulse must carry the oldest outstanding byte, last
//   exactly STROBE_CYCLES, be preceded by a SETUP cycle and followed by a HOLD
//   cycle; level and in_ready follow from the queue occupancy and capacity.
//   Directed steps cover latency, RECOVER exits, txe gating, bursts and reset.
// ----------------------------------------------------------------------------
module tb_ft_tx_engine;

    localparam int DEPTH = 8;
    localparam int SC    = 2;
    localparam int RM    = 4;
`ifdef FT_TX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_in = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       txe = 1'b1;
    logic       in_ready;
    logic       wr;
    logic [7:0] data_out;
    logic       data_oe;
    logic [6:0] level;

    ft_tx_engine #(
        .FIFO_DEPTH   (DEPTH),
        .STROBE_CYCLES(SC),
        .RECOVER_MAX  (RM)
    ) dut (
        .clk     (clk),
        .reset_in(reset_in),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .txe     (txe),
        .wr      (wr),
        .data_out(data_out),
        .data_oe (data_oe),
        .level   (level)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [7:0] q[$];      // accepted, not yet popped
    logic [7:0] src[$];    // bytes waiting to be offered
    logic [7:0] wlog[$];   // bytes seen on the bus at each wr fall
    logic       src_en = 1'b1;

    int   pop_pend = 0;
    int   wr_len   = 0;
    int   rises    = 0;
    int   falls    = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   acc_cyc  = 0;
    int   accs     = 0;
    int   max_lvl  = 0;
    int   nwritten = 0;
    logic prev_wr  = 1'b0;
    logic prev_oe  = 1'b0;
    logic chk_rec  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check pre-edge readiness, advance, update model, check.
    task automatic tick();
        logic exp_ready;
        logic do_push;
        logic has;
        in_valid = src_en && (src.size() > 0);
        in_data  = (src.size() > 0) ? src[0] : 8'h00;
        #1;
        exp_ready = reset_in && (q.size() < CAP);
        chk("in_ready", in_ready, exp_ready);
        do_push = in_valid && exp_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_in) begin
            q.delete();
            pop_pend = 0;
            wr_len   = 0;
            chk_rec  = 1'b0;
            chk("rst_wr", wr, 0);
            chk("rst_oe", data_oe, 0);
            chk("rst_data", data_out, 8'h00);
            chk("rst_level", level, 0);
        end else begin
            if (do_push) begin
                q.push_back(in_data);
                void'(src.pop_front());
                accs++;
                acc_cyc = cyc;
            end
            if (pop_pend != 0) begin
                void'(q.pop_front());
                pop_pend = 0;
            end
            chk("level", level, q.size());
            if (q.size() > max_lvl) max_lvl = q.size();
            if (chk_rec) begin
                chk("recover_oe", data_oe, 0);
                chk_rec = 1'b0;
            end
            has = (q.size() != 0);
            if (wr === 1'b1) begin
                if (!prev_wr) begin
                    chk("setup_oe", prev_oe, 1);
                    rises++;
                    rise_cyc = cyc;
                end
                wr_len++;
                chk("strobe_oe", data_oe, 1);
                chk("wr_nonempty", has, 1);
                if (has) chk("strobe_data", data_out, q[0]);
            end else if (prev_wr) begin
                falls++;
                fall_cyc = cyc;
                chk("strobe_len", wr_len, SC);
                wr_len = 0;
                chk("hold_oe", data_oe, 1);
                chk("hold_nonempty", has, 1);
                if (has) chk("hold_data", data_out, q[0]);
                wlog.push_back(data_out);
                nwritten++;
                pop_pend = 1;
                chk_rec  = 1'b1;
            end
        end
        prev_wr = wr;
        prev_oe = data_oe;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_rise(input int budget);
        int r0;
        int k;
        r0 = rises;
        k  = 0;
        while (rises == r0 && k < budget) begin
            tick();
            k++;
        end
        chk("rise_timeout", rises != r0, 1);
    endtask

    task automatic wait_fall(input int budget);
        int f0;
        int k;
        f0 = falls;
        k  = 0;
        while (falls == f0 && k < budget) begin
            tick();
            k++;
        end
        chk("fall_timeout", falls != f0, 1);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((q.size() != 0 || src.size() != 0 || pop_pend != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_timeout", (q.size() == 0) && (src.size() == 0), 1);
    endtask

    task automatic wait_accepts(input int target, input int budget);
        int k;
        k = 0;
        while (accs < target && k < budget) begin
            tick();
            k++;
        end
        chk("accept_timeout", accs >= target, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int f0;
        int r0;
        int w0;
        int a0;
        int a1;
        int a2;

        // Reset, then idle with txe low and nothing buffered.
        reset_in = 1'b0;
        txe      = 1'b1;
        run(3);
        reset_in = 1'b1;
        txe      = 1'b0;
        run(2);
        chk("idle_no_wr", rises, 0);

        // Single byte: exact cycle-by-cycle write sequence.
        src.push_back(8'hA5);
        tick();
        t0 = acc_cyc;
        chk("a5_accepted", accs, 1);
        chk("a5_idle_oe", data_oe, 0);
        tick();
        chk("a5_setup_oe", data_oe, 1);
        chk("a5_setup_wr", wr, 0);
        chk("a5_setup_data", data_out, 8'hA5);
        for (int i = 0; i < SC; i++) begin
            tick();
            chk("a5_strobe_wr", wr, 1);
            chk("a5_strobe_data", data_out, 8'hA5);
        end
        chk("a5_latency", rise_cyc - t0, 2);
        tick();
        chk("a5_hold_wr", wr, 0);
        chk("a5_hold_oe", data_oe, 1);
        chk("a5_hold_data", data_out, 8'hA5);
        tick();
        chk("a5_level_after", level, 0);
        chk("a5_recover_oe", data_oe, 0);
        run(RM + 2);

        // RECOVER with txe stuck low runs its full length.
        src.push_back(8'h11);
        src.push_back(8'h22);
        wait_fall(30);
        f0 = fall_cyc;
        wait_rise(30);
        chk("recover_max_gap", rise_cyc - f0, RM + 3);
        wait_fall(30);
        f0 = fall_cyc;

        // RECOVER exits on a sampled txe high.
        src.push_back(8'h33);
        tick();
        txe = 1'b1;
        tick();
        txe = 1'b0;
        wait_rise(30);
        chk("recover_txe_gap", rise_cyc - f0, 4);
        wait_drain(60);

        // txe held high: nothing written while bytes wait.
        txe = 1'b1;
        r0  = rises;
        w0  = nwritten;
        src.push_back(8'hB0);
        src.push_back(8'hB1);
        src.push_back(8'hB2);
        run(12);
        chk("txe_hold_no_wr", rises, r0);
        chk("txe_hold_level", level, (CAP < 3) ? CAP : 3);
        txe = 1'b0;
        wait_drain(150);
        chk("txe_release_writes", nwritten - w0, 3);

        // Burst of ten bytes; capacity must be reached and nothing lost.
        run(RM + 2);
        max_lvl = 0;
        w0 = nwritten;
        for (int i = 0; i < 10; i++) src.push_back(8'(i));
        wait_drain(400);
        chk("burst_count", nwritten - w0, 10);
        chk("burst_max_level", max_lvl, CAP);
        for (int i = 0; i < 10; i++) begin
            if (w0 + i < wlog.size()) chk("burst_order", wlog[w0 + i], i);
            else chk("burst_order_missing", w0 + i, wlog.size());
        end
        run(RM + 2);

        // Reset in the second STROBE cycle discards everything.
        txe = 1'b1;
        for (int i = 0; i < 5; i++) src.push_back(8'h50 + 8'(i));
        run(8);
        chk("prerst_level", level, (CAP < 5) ? CAP : 5);
        txe = 1'b0;
        wait_rise(20);
        tick();
        chk("rst_in_strobe2", wr, 1);
        src.delete();
        reset_in = 1'b0;
        tick();
        chk("rst_edge_wr", wr, 0);
        chk("rst_edge_oe", data_oe, 0);
        chk("rst_edge_level", level, 0);
        chk("rst_edge_ready", in_ready, 0);
        reset_in = 1'b1;
        r0 = rises;
        run(6);
        chk("rst_discard_no_wr", rises, r0);

        // Second byte offered while the first is outstanding.
        a0 = accs;
        w0 = nwritten;
        src.push_back(8'h3C);
        src.push_back(8'h3D);
        wait_accepts(a0 + 1, 20);
        a1 = acc_cyc;
        wait_accepts(a0 + 2, 40);
        a2 = acc_cyc;
`ifdef FT_TX_FIFO_EN
        chk("second_accept", a2 - a1, 1);
`else
        chk("stall_until_hold", a2 - fall_cyc, 2);
`endif
        wait_drain(60);
        chk("stall_writes", nwritten - w0, 2);
        if (w0 + 1 < wlog.size()) begin
            chk("stall_first", wlog[w0], 8'h3C);
            chk("stall_second", wlog[w0 + 1], 8'h3D);
        end else begin
            chk("stall_log_missing", wlog.size(), w0 + 2);
        end

        // Random traffic with random txe and upstream gaps.
        a0 = accs;
        w0 = nwritten;
        for (int i = 0; i < 600; i++) begin
            src_en = ($urandom_range(0, 3) != 0);
            txe    = ($urandom_range(0, 2) == 0);
            if (src.size() < 4 && $urandom_range(0, 1) == 1) src.push_back(8'($urandom));
            tick();
        end
        src_en = 1'b1;
        txe    = 1'b0;
        wait_drain(800);
        chk("random_all_written", nwritten - w0, accs - a0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
